// File: rtl/mem_arbiter.sv
// Round-robin arbiter between IFU and LSU for a single-port memory.
// One transaction in flight at a time, with a sticky watchdog on missing responses.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        err_timeout
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic          owner_lsu;
    logic          last_lsu;
    logic          grant_ifu, grant_lsu;
    logic [CW-1:0] wd_cnt;
    logic          wd_expire;
    logic [31:0]   byte_mask;
    logic [31:0]   resp_data;

    // Ready is gated by rst_n so that no grant is offered while reset is held.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (rst_n && state == IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_lsu = !last_lsu;
                grant_ifu = last_lsu;
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign wd_expire = (wd_cnt == CW'(TIMEOUT - 1));
    assign byte_mask = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}},
                        {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};

    always_comb begin
        resp_data = mem_rdata;
        if (mem_wen) begin
            resp_data = '0;
        end else if (owner_lsu) begin
            resp_data = mem_rdata & byte_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_ifu || grant_lsu) state_nxt = REQ;
            REQ:     if (mem_req_ready) state_nxt = WAIT;
            WAIT:    if (mem_resp_valid || wd_expire) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready  = grant_ifu;
        lsu_req_ready  = grant_lsu;
        mem_req_valid  = (state == REQ);
        ifu_resp_valid = (state == RESP) && !owner_lsu;
        lsu_resp_valid = (state == RESP) && owner_lsu;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            owner_lsu   <= 1'b0;
            last_lsu    <= 1'b0;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
            ifu_rdata   <= '0;
            lsu_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        mem_wen   <= lsu_wen;
                        mem_addr  <= lsu_addr;
                        mem_wdata <= lsu_wdata;
                        mem_wmask <= lsu_wmask;
                    end else if (grant_ifu) begin
                        mem_wen   <= 1'b0;
                        mem_addr  <= ifu_addr;
                        mem_wdata <= '0;
                        mem_wmask <= '1;
                    end
                    if (grant_ifu || grant_lsu) begin
                        owner_lsu <= grant_lsu;
                        last_lsu  <= grant_lsu;
                    end
                end
                REQ: begin
                    if (mem_req_ready) wd_cnt <= '0;
                end
                WAIT: begin
                    // A real response wins over expiry in the same cycle.
                    if (mem_resp_valid) begin
                        if (owner_lsu) lsu_rdata <= resp_data;
                        else           ifu_rdata <= resp_data;
                    end else if (wd_expire) begin
                        err_timeout <= 1'b1;
                        if (owner_lsu) lsu_rdata <= 32'hDEADBEEF;
                        else           ifu_rdata <= 32'hDEADBEEF;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port DPI-backed memory between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts one request at a time via valid/ready, forwards it to the memory port, waits for the response and returns it to the originating requester. Round-robin grant prevents starvation, and a watchdog flags memory responses that never arrive. It sits between the core's IFU/LSU and the memory model wrapper.

## Interface

- TIMEOUT, default 255: max cycles in WAIT before `err_timeout` sets; counter width is clog2(TIMEOUT+1).
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  IFU fetch address.
- ifu_resp_valid  out  1  one-cycle pulse: `ifu_rdata` valid.
- ifu_rdata  out  32  fetched word.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_addr  in  32  LSU address.
- lsu_wdata  in  32  write data.
- lsu_wmask  in  4  byte mask; for reads it selects the returned bytes.
- lsu_resp_valid  out  1  one-cycle pulse: read data valid, or write acknowledged.
- lsu_rdata  out  32  read data; 0 for writes.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/32/32/4  latched request fields.
- mem_resp_valid  in  1  memory response strobe.
- mem_rdata  in  32  memory read data.
- err_timeout  out  1  sticky watchdog flag.

## Operation

- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - If either requester is valid, grant one combinationally: assert only that requester's `*_req_ready`.
  - Latch its fields into the mem_* registers. IFU requests latch wen=0, wmask=4'hF, wdata=0.
  - Record the owner and go to REQ.
- **Arbitration**: round-robin with a `last` bit.
  - When both are valid, grant the requester not granted last.
  - When only one is valid, grant it.
  - `last` updates on every grant. Its reset value is IFU, so the LSU wins the first conflict.
- **REQ**: `mem_req_valid`=1 and the fields are held stable. On `mem_req_ready`=1 go to WAIT. A response in the same cycle as acceptance is illegal and is ignored.
- **WAIT**: when `mem_resp_valid`=1, latch `mem_rdata` into the owner's rdata register and go to RESP.
  - Writes latch 0 instead of the memory data.
  - LSU reads latch `mem_rdata` ANDed with the byte-expanded wmask.
- **RESP**: pulse the owner's `*_resp_valid` for exactly one cycle, then go to IDLE.
  - `*_req_ready` is 0 in RESP, so there is no back-to-back issue.
  - `*_rdata` holds its value until the owner's next response.
- **Watchdog**
  - The counter clears when entering WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT: set `err_timeout` (sticky until reset), force-complete the transaction with rdata=32'hDEADBEEF, and go to RESP.
- **Reset**: asserting reset mid-transaction aborts it. No response is delivered, and the requester must reissue.
- Reset values: all ready/valid outputs 0, all data outputs 0, `err_timeout` 0, `last`=IFU.

## Timing

- Request handshake is in cycle T (valid && ready).
- `mem_req_valid` is high from T+1.
- If `mem_req_ready` is high at T+1 and `mem_resp_valid` arrives at T+1+k (k≥1), `*_resp_valid` is high at T+2+k.
- Minimum request-to-response latency is 3 cycles. Minimum spacing between grants is 4 cycles.
- `*_req_ready` depends combinationally on `*_req_valid` and the state only, never on mem_* inputs.
- A requester may drop valid before it is granted. Fields are sampled only in the grant cycle.
- `mem_resp_valid` outside WAIT is ignored.

## Test plan

- **Single IFU read**
  - Stimulus: IFU addr 0x80000000; memory returns 0x00000413 one cycle after accept.
  - Required: `ifu_resp_valid` pulses 3 cycles after the handshake with rdata 0x00000413; LSU outputs stay idle.
- **Simultaneous requests from reset**
  - Stimulus: both valid continuously.
  - Required: grant order is LSU, IFU, LSU, IFU; each response goes only to its owner.
- **LSU write**
  - Stimulus: addr 0x80001000, wdata 0x12345678, wmask 4'b0011.
  - Required: mem_* fields match exactly throughout REQ; `lsu_resp_valid` pulses with `lsu_rdata`=0.
- **LSU masked read**
  - Stimulus: wmask 4'b1100; memory returns 0xAABBCCDD.
  - Required: `lsu_rdata`=0xAABB0000.
- **Backpressure and timeout**
  - Stimulus: hold `mem_req_ready`=0 for 5 cycles, then never assert `mem_resp_valid`; TIMEOUT=8.
  - Required: fields stay stable during backpressure; after 8 WAIT cycles `err_timeout`=1 and the owner receives 0xDEADBEEF.
- **Reset mid-transaction**
  - Stimulus: drop reset while in WAIT.
  - Required: all outputs 0 immediately (asynchronous); after release, a new IFU request completes normally and `err_timeout`=0.
